// File: rtl/sdspi_writer_pkg.sv
// Shared types and defaults for the SD-SPI sector writer.
// Holds the state and error encodings that are exported on the debug status word.
package sdspi_writer_pkg;

  localparam logic [15:0] SDSPI_DEVADDR     = 16'h0100;
  localparam logic [15:0] SDSPI_BLOCKADDR   = 16'h0200;
  localparam logic [15:0] SDSPI_WCMD_OFFSET = 16'h0004;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StFill     = 3'd1,
    StBwr      = 3'd2,
    StCmd      = 3'd3,
    StWaitBusy = 3'd4,
    StWaitIdle = 3'd5,
    StDone     = 3'd6
  } wr_state_e;

  typedef enum logic [1:0] {
    ErrNone     = 2'd0,
    ErrBus      = 2'd1,
    ErrStartTo  = 2'd2,
    ErrFinishTo = 2'd3
  } wr_err_e;

  function automatic logic [31:0] status_word(wr_state_e st, wr_err_e err);
    return {16'h0, 6'h0, err, 5'h0, st};
  endfunction

endpackage

// File: rtl/sdspi_writer_apb_single.sv
// One-shot APB-style write/read access engine; holds address and data stable until pready.
module sdspi_apb_single (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [15:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        write_i,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [15:0] paddr_o,
  output logic [31:0] pwdata_o,
  input  logic        pready_i,
  input  logic        pslverr_i,
  output logic        done_o,
  output logic        err_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      pwrite_o  <= 1'b0;
      paddr_o   <= 16'h0;
      pwdata_o  <= 32'h0;
    end else if (psel_o && pready_i) begin
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      pwrite_o  <= 1'b0;
    end else if (start_i && !psel_o) begin
      psel_o    <= 1'b1;
      penable_o <= 1'b1;
      pwrite_o  <= write_i;
      paddr_o   <= addr_i;
      pwdata_o  <= wdata_i;
    end
  end

  assign done_o = psel_o && pready_i;
  assign err_o  = done_o && pslverr_i;

endmodule

// File: rtl/sdspi_writer.sv
// Copies one user sector into the SD controller buffer, issues the write command,
// then waits for the card write to start and finish.
module sdspi_writer
  import sdspi_writer_pkg::*;
#(
  parameter logic [15:0] DEVADDR   = SDSPI_DEVADDR,
  parameter logic [15:0] BLOCKADDR = SDSPI_BLOCKADDR,
  parameter int unsigned BLOCKSIZE = 512,
  parameter logic [15:0] WCMD_OFF  = SDSPI_WCMD_OFFSET,
  parameter int unsigned TIMEOUT   = 50_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] sdspi_status_i,
  input  logic        sdsbusy_i,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [15:0] paddr_o,
  output logic [31:0] pwdata_o,
  input  logic        pready_i,
  input  logic        pslverr_i,
  input  logic        wstart_i,
  input  logic [31:0] wsector_i,
  output logic        wbusy_o,
  output logic        wdone_o,
  output logic        werr_o,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [7:0]  in_byte_i,
  output logic [8:0]  in_addr_o,
  output logic [31:0] w_writer_status_o
);

  localparam int unsigned TimerW  = $clog2(TIMEOUT + 1);
  localparam logic [8:0]  IdxMask = 9'(BLOCKSIZE - 1);

  wr_state_e         state_q;
  wr_err_e           err_q;
  logic [8:0]        idx_q;
  logic [TimerW-1:0] timer_q;
  logic [31:0]       sector_q;
  logic              wbusy_q, wdone_q, werr_q;

  logic        bus_start, bus_done, bus_err;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        accept, byte_take, card_active, card_idle, timed_out;
  logic        unused_status;

  assign unused_status = ^sdspi_status_i[31:16];
  assign card_idle     = !sdsbusy_i && (sdspi_status_i[15:0] == 16'h0);
  assign card_active   = sdsbusy_i && (sdspi_status_i[7:0] != 8'h0);
  assign accept        = (state_q == StIdle) && wstart_i && card_idle && !pready_i;
  assign timed_out     = (timer_q >= TimerW'(TIMEOUT));

  assign in_ready_o = (state_q == StFill) && !pready_i;
  assign in_addr_o  = idx_q;
  assign byte_take  = in_valid_i && in_ready_o;

  // The command access launches once the previous byte access has fully retired.
  assign bus_start = byte_take || ((state_q == StCmd) && !psel_o && !pready_i);
  assign bus_addr  = (state_q == StCmd) ? DEVADDR + WCMD_OFF
                                        : BLOCKADDR + {7'h0, idx_q & IdxMask};
  assign bus_wdata = (state_q == StCmd) ? sector_q : {24'h0, in_byte_i};

  sdspi_apb_single u_apb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (bus_start),
    .addr_i    (bus_addr),
    .wdata_i   (bus_wdata),
    .write_i   (1'b1),
    .psel_o    (psel_o),
    .penable_o (penable_o),
    .pwrite_o  (pwrite_o),
    .paddr_o   (paddr_o),
    .pwdata_o  (pwdata_o),
    .pready_i  (pready_i),
    .pslverr_i (pslverr_i),
    .done_o    (bus_done),
    .err_o     (bus_err)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      err_q    <= ErrNone;
      idx_q    <= 9'h0;
      timer_q  <= '0;
      sector_q <= 32'h0;
      wbusy_q  <= 1'b0;
      wdone_q  <= 1'b0;
      werr_q   <= 1'b0;
    end else begin
      wdone_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            sector_q <= wsector_i;
            idx_q    <= 9'h0;
            err_q    <= ErrNone;
            werr_q   <= 1'b0;
            wbusy_q  <= 1'b1;
            state_q  <= StFill;
          end
        end
        StFill: begin
          if (byte_take) state_q <= StBwr;
        end
        StBwr: begin
          if (bus_done) begin
            if (bus_err) begin
              err_q   <= ErrBus;
              werr_q  <= 1'b1;
              wdone_q <= 1'b1;
              wbusy_q <= 1'b0;
              state_q <= StDone;
            end else if (idx_q == IdxMask) begin
              state_q <= StCmd;
            end else begin
              idx_q   <= idx_q + 9'd1;
              state_q <= StFill;
            end
          end
        end
        StCmd: begin
          if (bus_done) begin
            if (bus_err) begin
              err_q   <= ErrBus;
              werr_q  <= 1'b1;
              wdone_q <= 1'b1;
              wbusy_q <= 1'b0;
              state_q <= StDone;
            end else begin
              timer_q <= '0;
              state_q <= StWaitBusy;
            end
          end
        end
        StWaitBusy: begin
          if (card_active) begin
            timer_q <= '0;
            state_q <= StWaitIdle;
          end else if (timed_out) begin
            err_q   <= ErrStartTo;
            werr_q  <= 1'b1;
            wdone_q <= 1'b1;
            wbusy_q <= 1'b0;
            state_q <= StDone;
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end
        StWaitIdle: begin
          if (card_idle) begin
            werr_q  <= (err_q != ErrNone);
            wdone_q <= 1'b1;
            wbusy_q <= 1'b0;
            state_q <= StDone;
          end else if (timed_out) begin
            err_q   <= ErrFinishTo;
            werr_q  <= 1'b1;
            wdone_q <= 1'b1;
            wbusy_q <= 1'b0;
            state_q <= StDone;
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign wbusy_o           = wbusy_q;
  assign wdone_o           = wdone_q;
  assign werr_o            = werr_q;
  assign w_writer_status_o = status_word(state_q, err_q);

endmodule

// File: tb/tb_sdspi_writer.sv
// Directed bench for sdspi_writer with an access-level scoreboard and a simple card model.
`timescale 1ns/1ps
module tb_sdspi_writer;

  localparam logic [15:0] DEV = 16'h0100;
  localparam logic [15:0] BLK = 16'h0200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] sdspi_status;
  logic        sdsbusy;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic        pready = 1'b0;
  logic        pslverr;
  logic        wstart = 1'b0;
  logic [31:0] wsector = 32'h0;
  logic        wbusy, wdone, werr;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_byte = 8'h0;
  logic [8:0]  in_addr;
  logic [31:0] wstat;

  int n_cmp = 0;
  int n_bad = 0;

  logic [47:0] exp_q[$];
  int          cycle = 0, cmd_cyc = -1, done_cyc = -1, bytes_done = 0;
  int          err_at_g = -1, card_mode = 0, card_t = -1;
  int          stall_at = -1, stall_cnt = 0;
  bit          pat_sel = 1'b0, force_busy = 1'b0, card_busy = 1'b0, psel_prev = 1'b0;
  logic [15:0] h_addr;
  logic [31:0] h_data, cap_ff, cap_cmd;

  always #5 clk = ~clk;

  sdspi_writer #(
    .DEVADDR   (DEV),
    .BLOCKADDR (BLK),
    .BLOCKSIZE (512),
    .WCMD_OFF  (16'h0004),
    .TIMEOUT   (1000)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .sdspi_status_i    (sdspi_status),
    .sdsbusy_i         (sdsbusy),
    .psel_o            (psel),
    .penable_o         (penable),
    .pwrite_o          (pwrite),
    .paddr_o           (paddr),
    .pwdata_o          (pwdata),
    .pready_i          (pready),
    .pslverr_i         (pslverr),
    .wstart_i          (wstart),
    .wsector_i         (wsector),
    .wbusy_o           (wbusy),
    .wdone_o           (wdone),
    .werr_o            (werr),
    .in_valid_i        (in_valid),
    .in_ready_o        (in_ready),
    .in_byte_i         (in_byte),
    .in_addr_o         (in_addr),
    .w_writer_status_o (wstat)
  );

  // Slave answers one cycle after seeing an access, for one cycle.
  always @(posedge clk) pready <= psel && penable && !pready;
  assign pslverr      = pready && (err_at_g >= 0) && (paddr == BLK + 16'(err_at_g));
  assign sdsbusy      = force_busy | card_busy;
  assign sdspi_status = card_busy ? 32'h0000_0101 : 32'h0;

  function automatic logic [7:0] pat(input int i);
    logic [7:0] b;
    b = 8'(i);
    return pat_sel ? (b ^ 8'h5A) : b;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Monitor, scoreboard, card model and byte producer, all sampled mid-cycle.
  always @(negedge clk) begin
    logic [47:0] e;
    cycle++;
    if (wdone) done_cyc = cycle;
    if (card_t >= 0) begin
      card_t++;
      if (card_t == 5) card_busy = 1'b1;
      if (card_t == 105) begin
        card_busy = 1'b0;
        card_t    = -1;
      end
    end
    if (psel && pready) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_access");
      end else begin
        e = exp_q.pop_front();
        check("bus_addr", 64'(paddr), 64'(e[47:32]));
        check("bus_data", 64'(pwdata), 64'(e[31:0]));
        check("bus_write", 64'(pwrite), 64'd1);
      end
      if (paddr == DEV + 16'h4) begin
        cmd_cyc = cycle;
        cap_cmd = pwdata;
        if (card_mode == 1) card_t = 0;
      end else begin
        bytes_done++;
      end
      if (paddr == 16'h02FF) cap_ff = pwdata;
    end
    if (psel && !psel_prev) begin
      h_addr = paddr;
      h_data = pwdata;
      check("penable_with_psel", 64'(penable), 64'd1);
    end else if (psel) begin
      check("addr_stable", 64'(paddr), 64'(h_addr));
      check("data_stable", 64'(pwdata), 64'(h_data));
    end
    psel_prev = psel;
    if (in_ready) check("in_addr", 64'(in_addr), 64'(bytes_done));
    if (in_ready && stall_at >= 0 && int'(in_addr) == stall_at && stall_cnt < 10) begin
      in_valid = 1'b0;
      stall_cnt++;
      check("stall_no_bus", 64'(psel), 64'd0);
    end else begin
      in_valid = 1'b1;
    end
    in_byte = pat(int'(in_addr));
  end

  task automatic run_xfer(input logic [31:0] sector, input int err_at, input int mode,
                          input int stall, input int rst_at, input int hold,
                          input logic [1:0] exp_code, input int lat_lo, input int lat_hi);
    int  n, c;
    bit  seen;
    n = (err_at >= 0) ? err_at + 1 : 512;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back({BLK + 16'(i), 24'h0, pat(i)});
    if (err_at < 0) exp_q.push_back({DEV + 16'h4, sector});
    err_at_g   = err_at;
    card_mode  = mode;
    stall_at   = stall;
    stall_cnt  = 0;
    bytes_done = 0;
    cmd_cyc    = -1;
    done_cyc   = -1;
    wsector    = sector;
    wstart     = 1'b1;
    c = 0;
    while (!wbusy && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (!wbusy) begin
      fail_now("accept_timeout");
      wstart = 1'b0;
      return;
    end
    check("accept_werr_clear", 64'(werr), 64'd0);
    check("accept_state_fill", 64'(wstat[7:0]), 64'd1);
    seen = 1'b0;
    c = 0;
    while (!seen && c < 4000) begin
      if (c == hold) wstart = 1'b0;
      @(negedge clk);
      c++;
      if (rst_at >= 0 && wbusy && int'(in_addr) == rst_at) begin
        rst = 1'b1;
        #1;
        check("rst_ctrl_zero", 64'({psel, penable, pwrite, wbusy, wdone, werr, in_ready}), 64'd0);
        check("rst_paddr", 64'(paddr), 64'd0);
        check("rst_pwdata", 64'(pwdata), 64'd0);
        check("rst_in_addr", 64'(in_addr), 64'd0);
        check("rst_status", 64'(wstat), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        wstart = 1'b0;
        exp_q.delete();
        return;
      end
      if (wdone) seen = 1'b1;
    end
    wstart = 1'b0;
    if (!seen) begin
      fail_now("wdone_timeout");
      return;
    end
    #1;
    check("werr", 64'(werr), 64'(exp_code != 2'd0));
    check("errcode", 64'(wstat[9:8]), 64'(exp_code));
    check("state_done", 64'(wstat[7:0]), 64'd6);
    check("wbusy_at_done", 64'(wbusy), 64'd0);
    check("all_accesses_seen", 64'(exp_q.size()), 64'd0);
    if (lat_lo >= 0) begin
      n_cmp++;
      if (cmd_cyc < 0 || done_cyc - cmd_cyc < lat_lo || done_cyc - cmd_cyc > lat_hi) begin
        n_bad++;
        $display("FAIL cmd_to_done: got %0d cycles expected %0d..%0d",
                 done_cyc - cmd_cyc, lat_lo, lat_hi);
      end
    end
    @(negedge clk);
    check("wdone_one_cycle", 64'(wdone), 64'd0);
    check("state_idle", 64'(wstat[7:0]), 64'd0);
    check("werr_held", 64'(werr), 64'(exp_code != 2'd0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_ctrl", 64'({psel, penable, pwrite, wbusy, wdone, werr, in_ready}), 64'd0);
    check("reset_bus", 64'({paddr, pwdata}), 64'd0);
    check("reset_status", 64'(wstat), 64'd0);
    check("reset_in_addr", 64'(in_addr), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Happy path with identity pattern.
    pat_sel = 1'b0;
    run_xfer(32'h0000_1234, -1, 1, -1, -1, 0, 2'd0, 104, 108);
    check("lit_cmd_data", 64'(cap_cmd), 64'h1234);
    check("lit_byte255", 64'(cap_ff), 64'hFF);

    // Producer stall at index 200.
    pat_sel = 1'b1;
    run_xfer(32'hCAFE_0001, -1, 1, 200, -1, 0, 2'd0, 104, 108);
    check("stall_cycles", 64'(stall_cnt), 64'd10);

    // Bus error on byte 37.
    run_xfer(32'h0000_0055, 37, 1, -1, -1, 0, 2'd1, -1, -1);

    // Card never starts: start timeout.
    run_xfer(32'h0000_0077, -1, 0, -1, -1, 0, 2'd2, 1000, 1004);

    // Reset mid-transfer, then a clean restart from index 0.
    run_xfer(32'h0000_0088, -1, 1, -1, 300, 0, 2'd0, -1, -1);
    @(negedge clk);
    run_xfer(32'h0000_0099, -1, 1, -1, -1, 0, 2'd0, 104, 108);

    // Request while the controller is busy is held off; wstart during FILL is ignored.
    force_busy = 1'b1;
    wstart     = 1'b1;
    repeat (6) @(negedge clk);
    check("busy_no_accept", 64'(wbusy), 64'd0);
    force_busy = 1'b0;
    run_xfer(32'h0000_00AA, -1, 1, -1, -1, 20, 2'd0, 104, 108);
    repeat (5) @(negedge clk);
    check("no_retrigger", 64'(wbusy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
